codec_cfg_sequencer: RTL
========================

// Module: codec_cfg_sequencer
// PURPOSE
//   Upstream driver for the 24-bit I2C write serializer: walks a fixed ROM of 11 WM8731 register
//   writes after power-up and hands each one over as {device address, 16-bit reg word} with a GO pulse.
//   Waits for the serializer's ready handshake, checks ACK, retries failed words, reports done/error.
//   Runs on the same slow I2C bit clock as the serializer.
// PARAMETERS
//   DEV_ADDR    8'h34   I2C write address placed in o_data[23:16]
//   INIT_DELAY  16'd200 clk cycles waited after reset before the first write
//   MAX_RETRY   2       retries per ROM entry (MAX_RETRY+1 attempts total) before error
//   TIMEOUT     16'd100 clk cycles allowed in each handshake wait phase
// PORTS
//   clk        in   1   I2C bit clock, shared with the serializer; all logic on posedge
//   reset      in   1   asynchronous, active-low
//   start      in   1   1-cycle pulse: re-run full table; honoured only in DONE or ERROR
//   o_go       out  1   1-cycle GO pulse to serializer
//   o_data     out  24  {DEV_ADDR, ROM[o_index]}, stable from GO until the word completes
//   i_ready    in   1   serializer ready: high = idle/finished, low = transfer in progress
//   i_ack      in   1   serializer ACK status: 0 = acknowledged, 1 = NACK; valid when i_ready rises
//   o_busy     out  1   high from reset or start until DONE/ERROR
//   o_done     out  1   high, held, after all 11 entries acknowledged
//   o_error    out  1   high, held, after an entry exhausts its retries
//   o_index    out  4   current ROM entry 0..10; frozen at the failing entry in ERROR
// BEHAVIOUR
//   Reset: o_go=0, o_data=0, o_busy=1, o_done=0, o_error=0, o_index=0, retry=0, state=DELAY.
//   ROM, 7-bit reg addr + 9-bit data:
//     0:1E00  1:0017  2:0217  3:0479  4:0679  5:0812
//     6:0A00  7:0C00  8:0E42  9:1000  10:1201
//   DELAY: count INIT_DELAY cycles -> LOAD.
//   LOAD: register o_data; assert o_go for exactly 1 cycle; clear timer -> WAIT_LO.
//   WAIT_LO: i_ready==0 -> WAIT_HI. TIMEOUT cycles without it -> FAIL.
//   WAIT_HI: i_ready==1 -> CHECK. TIMEOUT cycles without it -> FAIL.
//   CHECK: sample i_ack, 1 cycle.
//     - i_ack==0 and o_index==10 -> DONE.
//     - i_ack==0 otherwise -> o_index+1, retry=0, LOAD.
//     - i_ack==1 -> FAIL.
//   FAIL: retry==MAX_RETRY -> ERROR. Otherwise retry+1 and LOAD with the same o_index,
//     so the identical word is resent.
//   DONE: o_busy=0, o_done=1. ERROR: o_busy=0, o_error=1.
//   start in DONE/ERROR: clear done/error/o_index/retry; o_busy=1; -> LOAD next cycle (no DELAY).
//   start in any other state: ignored.
//   o_go never reasserts before i_ready has gone low then high again, or a timeout fires.
//   Timers are 16 bits and saturate; o_index never exceeds 10 and never wraps.
//   i_ready sampled directly, no synchroniser (same clock).
//   Reset mid-transfer: everything returns to reset values at once; o_go drops immediately.
// TESTING
//   1 Nominal: behavioural serializer model (ready low 33 cycles, ack=0) -> 11 GO pulses;
//     o_data 341E00,340017,...,341201; o_done=1, o_busy=0 after the last.
//   2 Single NACK: i_ack=1 on entry 3, first attempt only -> 12 GO pulses, 340479 sent twice,
//     then o_done=1.
//   3 Persistent NACK on entry 5, MAX_RETRY=2 -> exactly 3 GO pulses with 340812;
//     o_error=1, o_index=5, no further GO.
//   4 Timeout: i_ready held high after GO -> FAIL after 100 cycles, retried;
//     all attempts fail -> o_error=1.
//   5 Start: start pulse during busy -> no effect; start in DONE -> full 11-word rerun,
//     no INIT_DELAY wait.
//   6 Reset asserted during WAIT_HI of entry 4 -> outputs at reset values;
//     after release, INIT_DELAY cycles then first GO with 341E00.

Source files
------------

// File: rtl/codec_cfg_sequencer.sv
// Power-up configuration sequencer for a WM8731 codec: walks an 11-entry register ROM and hands
// each {device address, register word} to the I2C write serializer, retrying NACKed or stalled words.
module codec_cfg_sequencer #(
    parameter logic [7:0]  DEV_ADDR   = 8'h34,
    parameter logic [15:0] INIT_DELAY = 16'd200,
    parameter int          MAX_RETRY  = 2,
    parameter logic [15:0] TIMEOUT    = 16'd100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        o_go,
    output logic [23:0] o_data,
    input  logic        i_ready,
    input  logic        i_ack,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [3:0]  o_index,
    output logic [2:0]  o_state
);

    // Serializer handshake: o_go is a single-cycle request carrying o_data; the serializer
    // answers by dropping i_ready for the transfer and raising it again with i_ack valid.
    typedef enum logic [2:0] {
        S_DELAY   = 3'd0,
        S_LOAD    = 3'd1,
        S_WAIT_LO = 3'd2,
        S_WAIT_HI = 3'd3,
        S_CHECK   = 3'd4,
        S_FAIL    = 3'd5,
        S_DONE    = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    localparam logic [3:0] LAST_INDEX = 4'd10;
    localparam logic [3:0] RETRY_MAX  = 4'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  index_q, index_d;
    logic [3:0]  retry_q, retry_d;
    logic        go_q, go_d;
    logic [23:0] data_q, data_d;

    function automatic logic [15:0] rom_word(input logic [3:0] idx);
        case (idx)
            4'd0:    rom_word = 16'h1E00;
            4'd1:    rom_word = 16'h0017;
            4'd2:    rom_word = 16'h0217;
            4'd3:    rom_word = 16'h0479;
            4'd4:    rom_word = 16'h0679;
            4'd5:    rom_word = 16'h0812;
            4'd6:    rom_word = 16'h0A00;
            4'd7:    rom_word = 16'h0C00;
            4'd8:    rom_word = 16'h0E42;
            4'd9:    rom_word = 16'h1000;
            4'd10:   rom_word = 16'h1201;
            default: rom_word = 16'h0000;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        timer_d = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
        index_d = index_q;
        retry_d = retry_q;
        case (state_q)
            S_DELAY: begin
                if (timer_q >= INIT_DELAY - 16'd1) state_d = S_LOAD;
            end
            S_LOAD: begin
                timer_d = 16'd0;
                state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!i_ready) begin
                    timer_d = 16'd0;
                    state_d = S_WAIT_HI;
                end else if (timer_q >= TIMEOUT - 16'd1) begin
                    state_d = S_FAIL;
                end
            end
            S_WAIT_HI: begin
                if (i_ready) state_d = S_CHECK;
                else if (timer_q >= TIMEOUT - 16'd1) state_d = S_FAIL;
            end
            S_CHECK: begin
                if (i_ack) begin
                    state_d = S_FAIL;
                end else if (index_q >= LAST_INDEX) begin
                    state_d = S_DONE;
                end else begin
                    index_d = index_q + 4'd1;
                    retry_d = 4'd0;
                    state_d = S_LOAD;
                end
            end
            S_FAIL: begin
                if (retry_q >= RETRY_MAX) begin
                    state_d = S_ERROR;
                end else begin
                    retry_d = retry_q + 4'd1;
                    state_d = S_LOAD;
                end
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    index_d = 4'd0;
                    retry_d = 4'd0;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_DELAY;
        endcase
    end

    // GO and the data word are registered on entry to LOAD so both appear in the same cycle.
    always_comb begin
        go_d   = (state_d == S_LOAD);
        data_d = go_d ? {DEV_ADDR, rom_word(index_d)} : data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_DELAY;
            timer_q <= 16'd0;
            index_q <= 4'd0;
            retry_q <= 4'd0;
            go_q    <= 1'b0;
            data_q  <= 24'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            index_q <= index_d;
            retry_q <= retry_d;
            go_q    <= go_d;
            data_q  <= data_d;
        end
    end

    assign o_go    = go_q;
    assign o_data  = data_q;
    assign o_index = index_q;
    assign o_busy  = (state_q != S_DONE) && (state_q != S_ERROR);
    assign o_done  = (state_q == S_DONE);
    assign o_error = (state_q == S_ERROR);
    assign o_state = state_q;

endmodule
